bridge_reg_bank: RTL and testbench

BRIDGE_REG_BANK -- requirements
Module: bridge_reg_bank

---
 rtl/bridge_reg_bank.sv | 97 +++++++++
 tb/tb_bridge_reg_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bridge_reg_bank.sv
// Bridge-mapped bank of 32-bit registers with optional shadow/active staging
// and a CTRL register for commit/discard of staged writes.
module bridge_reg_bank #(
    parameter int                          NUM_REGS     = 4,
    parameter logic [31:0]                 BASE_ADDR    = 32'h00100000,
    parameter logic [NUM_REGS-1:0][31:0]   RESET_VALUES = '0,
    parameter bit                          SHADOW_MODE  = 1'b0
) (
    input  logic                     clk_74a,
    input  logic                     reset,
    input  logic [31:0]              bridge_addr,
    input  logic                     bridge_wr,
    input  logic [31:0]              bridge_wr_data,
    input  logic                     bridge_rd,
    output logic [31:0]              bridge_rd_data,
    output logic                     bridge_selected,
    input  logic                     commit,
    output logic [NUM_REGS*32-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    output logic [NUM_REGS-1:0]      pending
);

    logic [31:0]                 offset;
    logic                        hit_reg;
    logic                        hit_ctrl;
    logic [3:0]                  idx;
    logic [NUM_REGS-1:0][31:0]   shadow;
    logic [NUM_REGS-1:0][31:0]   active;
    logic [NUM_REGS-1:0]         wr_sel;
    logic                        commit_ev;
    logic                        discard_ev;
    logic [31:0]                 rd_next;
    logic [15:0]                 pending_ext;
    logic                        unused_rd;

    // Addresses below BASE_ADDR wrap to a huge offset and therefore miss.
    assign offset      = bridge_addr - BASE_ADDR;
    assign hit_reg     = (bridge_addr[1:0] == 2'b00) && (offset < 32'(4 * NUM_REGS));
    assign hit_ctrl    = (offset == 32'(4 * NUM_REGS));
    assign idx         = offset[5:2];
    assign pending_ext = 16'(pending);
    assign unused_rd   = bridge_rd;

    // Commit takes priority over discard when both CTRL bits are set.
    assign commit_ev  = SHADOW_MODE && (commit || (bridge_wr && hit_ctrl && bridge_wr_data[0]));
    assign discard_ev = SHADOW_MODE && !commit_ev && bridge_wr && hit_ctrl && bridge_wr_data[1];

    always_comb begin
        wr_sel  = '0;
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hit_reg && idx == 4'(i)) begin
                wr_sel[i] = bridge_wr;
                rd_next   = shadow[i];
            end
        end
        if (hit_ctrl)
            rd_next = {8'h00, 8'(NUM_REGS), pending_ext};
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            shadow          <= RESET_VALUES;
            active          <= RESET_VALUES;
            pending         <= '0;
            reg_wr_pulse    <= '0;
            bridge_rd_data  <= '0;
            bridge_selected <= 1'b0;
        end else begin
            // Read data samples the shadow before this cycle's write lands.
            bridge_rd_data  <= rd_next;
            bridge_selected <= hit_reg || hit_ctrl;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!SHADOW_MODE) begin
                    reg_wr_pulse[i] <= wr_sel[i];
                    if (wr_sel[i]) begin
                        shadow[i] <= bridge_wr_data;
                        active[i] <= bridge_wr_data;
                    end
                end else begin
                    reg_wr_pulse[i] <= commit_ev && pending[i];
                    if (commit_ev && pending[i])
                        active[i] <= shadow[i];
                    else if (discard_ev && pending[i])
                        shadow[i] <= active[i];
                    // A same-cycle write overrides the shadow after the old value was committed.
                    if (wr_sel[i])
                        shadow[i] <= bridge_wr_data;
                    pending[i] <= wr_sel[i] || (pending[i] && !commit_ev && !discard_ev);
                end
            end
        end
    end

    assign regs_out = active;

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Drives an immediate-mode and a shadow-mode bank with identical traffic and
// compares both against a queue-free array model of the register semantics.
module tb_bridge_reg_bank;

    localparam logic [31:0] BASE = 32'h00100000;
    localparam logic [3:0][31:0] RV = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         wr;
    logic [31:0]  wdata;
    logic         rd;
    logic         cm;
    logic [31:0]  rd0, rd1;
    logic         sel0, sel1;
    logic [127:0] regs0, regs1;
    logic [3:0]   pulse0, pulse1, pend0, pend1;

    logic [3:0][31:0] m_sh0, m_ac0, m_sh1, m_ac1;
    logic [3:0]       m_pend1, e_pulse0, e_pulse1;
    logic [31:0]      e_rd0, e_rd1;
    logic             e_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bridge_reg_bank #(.NUM_REGS(4), .BASE_ADDR(BASE), .RESET_VALUES(RV), .SHADOW_MODE(1'b0)) dut0 (
        .clk_74a(clk), .reset(rst), .bridge_addr(addr), .bridge_wr(wr), .bridge_wr_data(wdata),
        .bridge_rd(rd), .bridge_rd_data(rd0), .bridge_selected(sel0), .commit(cm),
        .regs_out(regs0), .reg_wr_pulse(pulse0), .pending(pend0));

    bridge_reg_bank #(.NUM_REGS(4), .BASE_ADDR(BASE), .RESET_VALUES(RV), .SHADOW_MODE(1'b1)) dut1 (
        .clk_74a(clk), .reset(rst), .bridge_addr(addr), .bridge_wr(wr), .bridge_wr_data(wdata),
        .bridge_rd(rd), .bridge_rd_data(rd1), .bridge_selected(sel1), .commit(cm),
        .regs_out(regs1), .reg_wr_pulse(pulse1), .pending(pend1));

    // -1 = miss, 0..3 = register, 4 = CTRL
    function automatic int decode(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a < BASE || a > BASE + 32'd16) return -1;
        return int'((a - BASE) / 32'd4);
    endfunction

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d, input logic c);
        int  k;
        logic ce, dc;
        rst = r; addr = a; wr = w; wdata = d; cm = c; rd = !w;
        if (r) begin
            m_sh0 = RV; m_ac0 = RV; m_sh1 = RV; m_ac1 = RV;
            m_pend1 = '0; e_pulse0 = '0; e_pulse1 = '0;
            e_rd0 = '0; e_rd1 = '0; e_sel = 1'b0;
        end else begin
            k = decode(a);
            e_sel = (k >= 0);
            e_rd0 = '0; e_rd1 = '0;
            if (k >= 0 && k < 4) begin
                e_rd0 = m_sh0[k];
                e_rd1 = m_sh1[k];
            end else if (k == 4) begin
                e_rd0 = 32'h0004_0000;
                e_rd1 = {16'h0004, 12'h000, m_pend1};
            end
            e_pulse0 = '0;
            if (w && k >= 0 && k < 4) begin
                m_sh0[k] = d; m_ac0[k] = d; e_pulse0[k] = 1'b1;
            end
            ce = c || (w && k == 4 && d[0]);
            dc = !ce && w && k == 4 && d[1];
            e_pulse1 = ce ? m_pend1 : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (m_pend1[i] && ce) m_ac1[i] = m_sh1[i];
                else if (m_pend1[i] && dc) m_sh1[i] = m_ac1[i];
            end
            if (ce || dc) m_pend1 = '0;
            if (w && k >= 0 && k < 4) begin
                m_sh1[k] = d; m_pend1[k] = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1'b1, BASE, 1'b1, 32'h1234, 1'b0);
        checks++; if (regs0 !== RV) begin errors++; $display("FAIL reset_regs0 got %h want %h", regs0, RV); end
        checks++; if (regs1 !== RV) begin errors++; $display("FAIL reset_regs1 got %h want %h", regs1, RV); end
        checks++; if ({pulse0, pulse1, pend0, pend1} !== 16'h0) begin errors++; $display("FAIL reset_flags got %h want 0", {pulse0, pulse1, pend0, pend1}); end
        checks++; if ({rd0, rd1, sel0, sel1} !== 66'h0) begin errors++; $display("FAIL reset_read got %h/%h sel %b%b want 0", rd0, rd1, sel0, sel1); end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_immediate();
        step(1'b0, BASE + 32'd4, 1'b1, 32'hDEADBEEF, 1'b0);
        checks++; if (regs0[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL imm_value got %h want deadbeef", regs0[63:32]); end
        checks++; if (pulse0 !== 4'b0010) begin errors++; $display("FAIL imm_pulse got %b want 0010", pulse0); end
        checks++; if (regs1 !== RV || pend1 !== 4'b0010) begin errors++; $display("FAIL shadow_staged got %h pend %b want %h pend 0010", regs1, pend1, RV); end
        step(1'b0, BASE + 32'd4, 1'b0, 32'h0, 1'b0);
        checks++; if (pulse0 !== 4'b0000) begin errors++; $display("FAIL imm_pulse_width got %b want 0000", pulse0); end
        checks++; if (rd0 !== 32'hDEADBEEF || rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL imm_readback got %h/%h want deadbeef", rd0, rd1); end
    endtask

    task automatic test_shadow_commit();
        step(1'b0, BASE + 32'd16, 1'b1, 32'h2, 1'b0);
        step(1'b0, BASE, 1'b1, 32'h55, 1'b0);
        step(1'b0, BASE + 32'd8, 1'b1, 32'hAA, 1'b0);
        checks++; if (pend1 !== 4'b0101 || regs1 !== RV) begin errors++; $display("FAIL stage_two got pend %b regs %h want 0101 %h", pend1, regs1, RV); end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++; if (pulse1 !== 4'b0101 || pend1 !== 4'b0000) begin errors++; $display("FAIL commit_flags got pulse %b pend %b want 0101 0000", pulse1, pend1); end
        checks++; if (regs1[31:0] !== 32'h55 || regs1[95:64] !== 32'hAA) begin errors++; $display("FAIL commit_values got %h %h want 55 aa", regs1[31:0], regs1[95:64]); end
        checks++; if (pulse0 !== 4'b0000) begin errors++; $display("FAIL imm_ignores_commit got %b want 0000", pulse0); end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (pulse1 !== 4'b0000) begin errors++; $display("FAIL commit_pulse_width got %b want 0000", pulse1); end
    endtask

    task automatic test_write_commit();
        step(1'b0, BASE + 32'd4, 1'b1, 32'd7, 1'b0);
        step(1'b0, BASE + 32'd4, 1'b1, 32'd9, 1'b1);
        checks++; if (regs1[63:32] !== 32'd7 || pend1 !== 4'b0010) begin errors++; $display("FAIL wr_commit got %h pend %b want 7 0010", regs1[63:32], pend1); end
        step(1'b0, BASE + 32'd4, 1'b0, 32'h0, 1'b0);
        checks++; if (rd1 !== 32'd9) begin errors++; $display("FAIL wr_commit_shadow got %h want 9", rd1); end
    endtask

    task automatic test_ctrl_read();
        step(1'b0, BASE, 1'b1, 32'h11, 1'b0);
        step(1'b0, BASE + 32'd16, 1'b0, 32'h0, 1'b0);
        checks++; if (rd1 !== 32'h00040003 || sel1 !== 1'b1) begin errors++; $display("FAIL ctrl_read got %h sel %b want 00040003 1", rd1, sel1); end
        checks++; if (rd0 !== 32'h00040000) begin errors++; $display("FAIL ctrl_read_imm got %h want 00040000", rd0); end
        step(1'b0, BASE + 32'd20, 1'b0, 32'h0, 1'b0);
        checks++; if (rd1 !== 32'h0 || sel1 !== 1'b0 || sel0 !== 1'b0) begin errors++; $display("FAIL miss_read got %h sel %b%b want 0 00", rd1, sel0, sel1); end
    endtask

    task automatic test_ctrl_write();
        step(1'b0, BASE + 32'd16, 1'b1, 32'h1, 1'b0);
        step(1'b0, BASE + 32'd12, 1'b1, 32'h33, 1'b0);
        step(1'b0, BASE + 32'd16, 1'b1, 32'h3, 1'b0);
        checks++; if (pulse1 !== 4'b1000 || pend1 !== 4'b0000 || regs1[127:96] !== 32'h33) begin errors++; $display("FAIL ctrl_both got pulse %b pend %b r3 %h want 1000 0000 33", pulse1, pend1, regs1[127:96]); end
        step(1'b0, BASE + 32'd12, 1'b1, 32'h44, 1'b0);
        step(1'b0, BASE + 32'd16, 1'b1, 32'h2, 1'b0);
        checks++; if (pulse1 !== 4'b0000 || pend1 !== 4'b0000) begin errors++; $display("FAIL discard_flags got pulse %b pend %b want 0000 0000", pulse1, pend1); end
        step(1'b0, BASE + 32'd12, 1'b0, 32'h0, 1'b0);
        checks++; if (rd1 !== 32'h33) begin errors++; $display("FAIL discard_revert got %h want 33", rd1); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] old0;
        old0 = m_sh0[2];
        step(1'b0, BASE + 32'd8, 1'b1, 32'hBEEF, 1'b0);
        checks++; if (rd0 !== old0) begin errors++; $display("FAIL rd_wr_same got %h want %h", rd0, old0); end
    endtask

    task automatic test_miss_writes();
        logic [127:0] before0;
        logic [3:0]   pend_before;
        before0 = regs0; pend_before = pend1;
        step(1'b0, BASE + 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checks++; if (sel0 !== 1'b0 || pulse0 !== 4'b0000) begin errors++; $display("FAIL unaligned got sel %b pulse %b want 0 0000", sel0, pulse0); end
        step(1'b0, BASE + 32'h40, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, BASE - 32'd4, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checks++; if (regs0 !== before0 || pend1 !== pend_before) begin errors++; $display("FAIL miss_write got %h pend %b want %h pend %b", regs0, pend1, before0, pend_before); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, BASE + 32'd8, 1'b1, 32'h1234, 1'b0);
        step(1'b1, BASE + 32'd8, 1'b1, 32'h5678, 1'b1);
        step(1'b0, BASE + 32'd8, 1'b0, 32'h0, 1'b0);
        checks++; if (rd1 !== RV[2] || pend1 !== 4'b0000 || regs1 !== RV) begin errors++; $display("FAIL reset_drops_staged got %h pend %b want %h 0000", rd1, pend1, RV[2]); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      a = BASE + 32'(4 * $urandom_range(0, 4));
            else if (r < 8) a = BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(1, 3));
            else if (r < 9) a = BASE + 32'd20 + 32'(4 * $urandom_range(0, 3));
            else            a = $urandom;
            step(1'b0, a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0));
            checks++; if (regs0 !== m_ac0 || regs1 !== m_ac1) begin errors++; $display("FAIL rnd_regs cyc %0d got %h/%h want %h/%h", n, regs0, regs1, m_ac0, m_ac1); end
            checks++; if (pulse0 !== e_pulse0 || pulse1 !== e_pulse1) begin errors++; $display("FAIL rnd_pulse cyc %0d got %b/%b want %b/%b", n, pulse0, pulse1, e_pulse0, e_pulse1); end
            checks++; if (pend0 !== 4'b0000 || pend1 !== m_pend1) begin errors++; $display("FAIL rnd_pending cyc %0d got %b/%b want 0000/%b", n, pend0, pend1, m_pend1); end
            checks++; if (rd0 !== e_rd0 || rd1 !== e_rd1) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", n, rd0, rd1, e_rd0, e_rd1); end
            checks++; if (sel0 !== e_sel || sel1 !== e_sel) begin errors++; $display("FAIL rnd_sel cyc %0d got %b%b want %b", n, sel0, sel1, e_sel); end
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; wr = 1'b0; wdata = '0; rd = 1'b0; cm = 1'b0;
        test_reset();
        test_immediate();
        test_shadow_commit();
        test_write_commit();
        test_ctrl_read();
        test_ctrl_write();
        test_read_during_write();
        test_miss_writes();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
